// File: rtl/imem_run_ctrl.sv
// imem_run_ctrl: host program loader into code memory plus CPU run/halt/step control.
// Define IMEM_RUN_CTRL_STEP_EN to enable single-stepping from HALT.
module imem_run_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_start,
    input  logic              host_valid,
    input  logic [26:0]       host_data,
    output logic              host_ready,
    input  logic              host_done,
    input  logic              host_halt,
    input  logic              host_step,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [26:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_pc_we,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, HALT = 3'd3, STEP = 3'd4} st_t;
`ifdef IMEM_RUN_CTRL_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    st_t  cur;
    logic we_q;
    logic accept;
    assign host_ready = (cur == LOAD) && (load_count < DEPTH);
    assign accept     = host_valid && host_ready && !host_start;
    // a reset arriving while a write is pending must suppress it
    assign imem_we    = we_q && !rst;
    assign cpu_rst    = (cur == IDLE) || (cur == LOAD);
    assign cpu_pc_we  = (cur == RUN) || (cur == STEP);
    assign state      = cur;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= IDLE;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            we_q <= accept;
            if (accept) begin
                imem_addr  <= load_count[ADDR_W-1:0];
                imem_wdata <= host_data;
                load_count <= load_count + 1'b1;
            end
            if (host_start) begin
                cur        <= LOAD;
                load_count <= '0;
                load_err   <= 1'b0;
            end else begin
                case (cur)
                    IDLE: cur <= IDLE;
                    LOAD: begin
                        if (host_valid && !host_ready)
                            load_err <= 1'b1;
                        if (host_done)
                            cur <= (load_count != '0 || accept) ? RUN : IDLE;
                    end
                    RUN:  cur <= host_halt ? HALT : RUN;
                    HALT: cur <= host_done ? RUN : (STEP_EN && host_step) ? STEP : HALT;
                    STEP: cur <= HALT;
                    default: cur <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_run_ctrl.sv
// tb_imem_run_ctrl: directed vector table plus hand-written overflow and reset sequences.
module tb_imem_run_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
`ifdef IMEM_RUN_CTRL_STEP_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif
    logic        rst, host_start, host_valid, host_done, host_halt, host_step;
    logic [26:0] host_data;
    logic        host_ready, imem_we, cpu_rst, cpu_pc_we, load_err;
    logic [7:0]  imem_addr;
    logic [26:0] imem_wdata;
    logic [2:0]  state;
    logic [8:0]  load_count;
    logic        ready2, we2, crst2, pcwe2, err2;
    logic [1:0]  addr2;
    logic [26:0] wdata2;
    logic [2:0]  state2, cnt2;
    imem_run_ctrl dut (
        .clk(clk), .rst(rst), .host_start(host_start), .host_valid(host_valid),
        .host_data(host_data), .host_ready(host_ready), .host_done(host_done),
        .host_halt(host_halt), .host_step(host_step), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .cpu_pc_we(cpu_pc_we), .state(state), .load_count(load_count), .load_err(load_err)
    );
    imem_run_ctrl #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .host_start(host_start), .host_valid(host_valid),
        .host_data(host_data), .host_ready(ready2), .host_done(host_done),
        .host_halt(host_halt), .host_step(host_step), .imem_we(we2),
        .imem_addr(addr2), .imem_wdata(wdata2), .cpu_rst(crst2),
        .cpu_pc_we(pcwe2), .state(state2), .load_count(cnt2), .load_err(err2)
    );
    typedef struct {
        logic        r, s, va;
        logic [26:0] d;
        logic        dn, h, stp;
        logic [2:0]  est;
        logic        ewe;
        logic [7:0]  ea;
        logic [26:0] ewd;
        logic        erdy, ecr, epc;
        logic [8:0]  ecnt;
        logic        eerr;
    } vec_t;
    vec_t tbl [13];
    int checks = 0;
    int failures = 0;
    function automatic vec_t mk(input logic r, s, va, input logic [26:0] d, input logic dn, h, stp,
                                input logic [2:0] est, input logic ewe, input logic [7:0] ea,
                                input logic [26:0] ewd, input logic erdy, ecr, epc,
                                input logic [8:0] ecnt, input logic eerr);
        vec_t v;
        v.r = r; v.s = s; v.va = va; v.d = d; v.dn = dn; v.h = h; v.stp = stp;
        v.est = est; v.ewe = ewe; v.ea = ea; v.ewd = ewd; v.erdy = erdy;
        v.ecr = ecr; v.epc = epc; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask
    task automatic drive(input logic r, s, va, input logic [26:0] d, input logic dn, h, stp);
        rst = r; host_start = s; host_valid = va; host_data = d;
        host_done = dn; host_halt = h; host_step = stp;
    endtask
    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        //            r  s  va d          dn h  st  state     we addr wdata      rdy cr pc   cnt err
        tbl[0]  = mk(1, 0, 0, 0,         0, 0, 0,  3'd0,     0, 0,   0,         0,  1, 0,  0,  0);
        tbl[1]  = mk(0, 1, 0, 0,         0, 0, 0,  3'd1,     0, 0,   0,         1,  1, 0,  0,  0);
        tbl[2]  = mk(0, 0, 1, 27'h1,     0, 0, 0,  3'd1,     1, 0,   27'h1,     1,  1, 0,  1,  0);
        tbl[3]  = mk(0, 0, 1, 27'h2,     0, 0, 0,  3'd1,     1, 1,   27'h2,     1,  1, 0,  2,  0);
        tbl[4]  = mk(0, 0, 1, 27'h4000004,0, 0, 0, 3'd1,     1, 2,   27'h4000004,1, 1, 0,  3,  0);
        tbl[5]  = mk(0, 0, 0, 0,         1, 0, 0,  3'd2,     0, 2,   27'h4000004,0, 0, 1,  3,  0);
        tbl[6]  = mk(0, 0, 0, 0,         0, 1, 0,  3'd3,     0, 2,   27'h4000004,0, 0, 0,  3,  0);
        tbl[7]  = mk(0, 0, 0, 0,         0, 0, 1,  SE ? 3'd4 : 3'd3, 0, 2, 27'h4000004, 0, 0, SE, 3, 0);
        tbl[8]  = mk(0, 0, 0, 0,         0, 0, 0,  3'd3,     0, 2,   27'h4000004,0, 0, 0,  3,  0);
        tbl[9]  = mk(0, 0, 0, 0,         1, 0, 1,  3'd2,     0, 2,   27'h4000004,0, 0, 1,  3,  0);
        tbl[10] = mk(0, 0, 0, 0,         1, 0, 1,  3'd2,     0, 2,   27'h4000004,0, 0, 1,  3,  0);
        tbl[11] = mk(0, 1, 0, 0,         0, 1, 0,  3'd1,     0, 2,   27'h4000004,1, 1, 0,  0,  0);
        tbl[12] = mk(0, 0, 0, 0,         1, 0, 0,  3'd0,     0, 2,   27'h4000004,0, 1, 0,  0,  0);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].va, tbl[i].d, tbl[i].dn, tbl[i].h, tbl[i].stp);
            @(posedge clk); #1;
            chk("state", i, 32'(state), 32'(tbl[i].est));
            chk("imem_we", i, 32'(imem_we), 32'(tbl[i].ewe));
            chk("imem_addr", i, 32'(imem_addr), 32'(tbl[i].ea));
            chk("imem_wdata", i, 32'(imem_wdata), 32'(tbl[i].ewd));
            chk("host_ready", i, 32'(host_ready), 32'(tbl[i].erdy));
            chk("cpu_rst", i, 32'(cpu_rst), 32'(tbl[i].ecr));
            chk("cpu_pc_we", i, 32'(cpu_pc_we), 32'(tbl[i].epc));
            chk("load_count", i, 32'(load_count), 32'(tbl[i].ecnt));
            chk("load_err", i, 32'(load_err), 32'(tbl[i].eerr));
        end
        // overflow on the 4-word instance
        drive(1, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0); @(posedge clk); #1;
        chk("ovf_ready0", 0, 32'(ready2), 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 27'(16 + k), 0, 0, 0);
            @(posedge clk); #1;
            chk("ovf_we", k, 32'(we2), 32'(k < 4));
            chk("ovf_addr", k, 32'(addr2), (k < 4) ? k : 3);
            chk("ovf_wdata", k, 32'(wdata2), (k < 4) ? 16 + k : 19);
            chk("ovf_cnt", k, 32'(cnt2), (k < 4) ? k + 1 : 4);
            chk("ovf_err", k, 32'(err2), 32'(k == 4));
            chk("ovf_ready", k, 32'(ready2), 32'(k < 3));
        end
        drive(0, 0, 0, 0, 1, 0, 0); @(posedge clk); #1;
        chk("ovf_run", 0, 32'(state2), 2);
        chk("ovf_err_hold", 0, 32'(err2), 1);
        chk("ovf_cnt_hold", 0, 32'(cnt2), 4);
        // reset right after a handshake must kill the pending write
        drive(1, 0, 0, 0, 0, 0, 0); @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0); @(posedge clk); #1;
        drive(0, 0, 1, 27'h55, 0, 0, 0); @(posedge clk);
        drive(1, 0, 0, 0, 0, 0, 0); #1;
        chk("rst_we_pending", 0, 32'(imem_we), 0);
        @(posedge clk); #1;
        chk("rst_state", 0, 32'(state), 0);
        chk("rst_we", 0, 32'(imem_we), 0);
        chk("rst_addr", 0, 32'(imem_addr), 0);
        chk("rst_wdata", 0, 32'(imem_wdata), 0);
        chk("rst_cnt", 0, 32'(load_count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_run_ctrl.md
IMEM_RUN_CTRL -- requirements
Module: imem_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the code-memory address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port host_start, input, 1 bit: request to begin or restart a program load.
REQ-005 SHALL have port host_valid, input, 1 bit: host_data holds a valid instruction word.
REQ-006 SHALL have port host_data, input, 27 bits: instruction word, as a 2-bit x, a 2-bit y and a 23-bit one-hot opcode.
REQ-007 SHALL have port host_ready, output, 1 bit: the block accepts host_data this cycle.
REQ-008 SHALL have port host_done, input, 1 bit: load complete, or resume from HALT.
REQ-009 SHALL have port host_halt, input, 1 bit: request to stop the CPU.
REQ-010 SHALL have port host_step, input, 1 bit: request to single-step the CPU.
REQ-011 SHALL have port imem_we, output, 1 bit: code-memory write enable.
REQ-012 SHALL have port imem_addr, output, ADDR_W bits: code-memory write address.
REQ-013 SHALL have port imem_wdata, output, 27 bits: code-memory write data.
REQ-014 SHALL have port cpu_rst, output, 1 bit: holds the CPU and its PC in reset.
REQ-015 SHALL have port cpu_pc_we, output, 1 bit: gates the CPU PC write enable.
REQ-016 SHALL have port state, output, 3 bits: the current FSM state.
REQ-017 SHALL have port load_count, output, ADDR_W+1 bits: number of words accepted in the current load.
REQ-018 SHALL have port load_err, output, 1 bit: sticky load-overflow flag.

Function
REQ-019 SHALL implement the states IDLE=0, LOAD=1, RUN=2, HALT=3 and STEP=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-020 SHALL drive cpu_rst=1 in IDLE and LOAD, and cpu_rst=0 otherwise; SHALL drive cpu_pc_we=1 only in RUN and STEP.
REQ-021 SHALL give host_start priority over all other host inputs; in any state, host_start moves the FSM to LOAD next cycle and clears load_count and load_err.
REQ-022 SHALL, in LOAD, drive host_ready=1 iff load_count<DEPTH; host_ready SHALL be 0 in every other state.
REQ-023 SHALL, on host_valid&host_ready, register imem_we=1, imem_addr=load_count[ADDR_W-1:0] and imem_wdata=host_data for exactly the next cycle, and increment load_count; the write latency is 1 cycle.
REQ-024 SHALL hold imem_we=0 in every cycle that does not follow an accepted handshake; imem_addr and imem_wdata hold their last values.
REQ-025 SHALL set load_err when host_valid=1 in LOAD with load_count==DEPTH (memory full); the word is dropped and load_count saturates at DEPTH.
REQ-026 SHALL, on host_done in LOAD, move to RUN if load_count>0, and to IDLE if load_count==0; a write registered in that same cycle SHALL still complete.
REQ-027 SHALL, in RUN, move to HALT on host_halt; host_done and host_step SHALL be ignored in RUN.
REQ-028 SHALL, in HALT, move to RUN on host_done, otherwise move to STEP on host_step; host_done wins when both are asserted.
REQ-029 SHALL hold STEP for exactly one cycle (cpu_pc_we=1 for that one cycle only) and then return unconditionally to HALT.
REQ-030 SHALL keep load_count and load_err stable outside LOAD until the next host_start or reset.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, enter IDLE and set imem_we=0, imem_addr=0, imem_wdata=0, host_ready=0, cpu_rst=1, cpu_pc_we=0, load_count=0 and load_err=0.
REQ-032 SHALL give rst priority over host_start; a reset during LOAD abandons the load, and any pending imem write SHALL NOT occur.

Configuration
REQ-033 SHALL, with macro IMEM_RUN_CTRL_STEP_EN defined, implement STEP exactly as REQ-028 and REQ-029.
REQ-034 SHALL, without IMEM_RUN_CTRL_STEP_EN, ignore host_step, leave STEP unreachable and keep all other behaviour identical.

Verification
REQ-035 SHALL cover: reset, then host_start, then 3 words 0x0000001, 0x0000002, 0x4000004 with host_valid held, then host_done -> imem writes to addresses 0,1,2 each one cycle after its handshake, load_count=3, then state=RUN, cpu_rst=0, cpu_pc_we=1.
REQ-036 SHALL cover: ADDR_W=2, 5 words streamed -> 4 writes to addresses 0-3, host_ready=0 after the 4th, load_err=1, load_count=4.
REQ-037 SHALL cover: in RUN, host_halt -> HALT with cpu_pc_we=0; host_step -> exactly one cycle of cpu_pc_we=1 and state 4, then back to state 3; without the macro, host_step -> no change.
REQ-038 SHALL cover: in HALT, host_done and host_step asserted together -> RUN; then host_start and host_halt together -> LOAD, with load_count=0 and load_err=0.
REQ-039 SHALL cover: host_done in LOAD with load_count=0 -> IDLE.
REQ-040 SHALL cover: rst asserted one cycle after a handshake -> imem_we stays 0 and state=IDLE.
